piso_serializer: RTL

Parallel-in/serial-out stage that feeds the 4-bit serial-in shift register. It accepts parallel words over a valid/ready handshake, buffers one word, and drives them out one bit per clock on `Dout`, LSB first by default. `Frame_done` pulses in the cycle when the downstream shift register holds the complete word on its parallel outputs.

---
 rtl/piso_pkg.sv | 20 ++
 rtl/piso_hold_reg.sv | 51 +++++
 rtl/piso_serializer.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// piso_pkg: shared definitions for the parallel-in/serial-out serializer.
//   state_t             - FSM state encoding (IDLE / SHIFT / GUARD)
//   PISO_WIDTH_DEFAULT  - default word width
//   cnt_bits()          - width of a counter that must reach the value 'width'
package piso_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GUARD = 2'd2
  } state_t;

  localparam int PISO_WIDTH_DEFAULT = 4;

  // The bit counter runs 1..width, so it must be able to hold 'width' itself.
  function automatic int cnt_bits(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/piso_hold_reg.sv
// piso_hold_reg: one-entry input buffer with pass-through ready.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_data/i_valid : offered parallel word
//   i_load         : consumer takes o_data on this edge
//   o_ready        : a word can be accepted on this edge
//   o_full/o_data  : buffer occupancy and contents
module piso_hold_reg
  import piso_pkg::*;
#(
  parameter int WIDTH = PISO_WIDTH_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  input  logic             i_load,
  output logic             o_ready,
  output logic             o_full,
  output logic [WIDTH-1:0] o_data
);

  logic             r_full;
  logic [WIDTH-1:0] r_data;
  logic             w_accept;

  // Ready also when the entry is being drained this edge, so a new word can
  // replace the departing one without a bubble.
  always_comb begin
    o_ready  = !r_full || i_load;
    w_accept = i_valid && o_ready;
  end

  // Buffer occupancy and contents; a same-edge accept wins over the drain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (w_accept) begin
      r_full <= 1'b1;
      r_data <= i_data;
    end else if (i_load) begin
      r_full <= 1'b0;
    end else begin
      r_full <= r_full;
    end
  end

  assign o_full = r_full;
  assign o_data = r_data;

endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in/serial-out stage with valid/ready input.
//   Clk, Rst_n          : clock, asynchronous active-low reset
//   Din_par/Din_valid   : parallel word offered
//   Din_ready           : word accepted on an edge with Din_valid && Din_ready
//   Dout/Dout_valid     : registered serial bit and its qualifier
//   Frame_done          : one-cycle pulse in the cycle after a word's last bit
//   Busy                : FSM not idle
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = PISO_WIDTH_DEFAULT,
  parameter bit LSB_FIRST = 1'b1,
  parameter int GAP       = 0
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [WIDTH-1:0] Din_par,
  input  logic             Din_valid,
  output logic             Din_ready,
  output logic             Dout,
  output logic             Dout_valid,
  output logic             Frame_done,
  output logic             Busy
);

  localparam int               CNT_W    = cnt_bits(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [3:0]       GAP_LOAD = 4'(GAP);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shreg, w_shreg_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]       r_gap_cnt, w_gap_cnt_nxt;
  logic             r_dout, w_dout_nxt;
  logic             r_dout_valid, w_dout_valid_nxt;
  logic             r_frame_done, w_frame_done_nxt;
  logic             r_busy;
  logic             w_load;
  logic             w_hold_full;
  logic [WIDTH-1:0] w_hold_data;

  // Bit that goes out first from a word in transmit order.
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return LSB_FIRST ? w[0] : w[WIDTH-1];
  endfunction

  // Move the next bit into the first-bit position.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return LSB_FIRST ? {1'b0, w[WIDTH-1:1]} : {w[WIDTH-2:0], 1'b0};
  endfunction

  piso_hold_reg #(
    .WIDTH (WIDTH)
  ) u_hold (
    .i_clk   (Clk),
    .i_rst_n (Rst_n),
    .i_data  (Din_par),
    .i_valid (Din_valid),
    .i_load  (w_load),
    .o_ready (Din_ready),
    .o_full  (w_hold_full),
    .o_data  (w_hold_data)
  );

  // Next-state, datapath and load decision.
  always_comb begin
    w_state_nxt      = r_state;
    w_shreg_nxt      = r_shreg;
    w_cnt_nxt        = r_cnt;
    w_gap_cnt_nxt    = r_gap_cnt;
    w_dout_nxt       = 1'b0;
    w_dout_valid_nxt = 1'b0;
    w_frame_done_nxt = 1'b0;
    w_load           = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_load = w_hold_full;
      end
      ST_SHIFT: begin
        if (r_cnt < CNT_LAST) begin
          w_dout_nxt       = first_bit(r_shreg);
          w_dout_valid_nxt = 1'b1;
          w_shreg_nxt      = advance(r_shreg);
          w_cnt_nxt        = r_cnt + CNT_ONE;
        end else begin
          // Last bit is on Dout: the word is complete at this edge.
          w_frame_done_nxt = 1'b1;
          if (GAP > 0) begin
            w_state_nxt   = ST_GUARD;
            w_gap_cnt_nxt = GAP_LOAD;
          end else if (w_hold_full) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_GUARD: begin
        w_gap_cnt_nxt = r_gap_cnt - 4'd1;
        if (r_gap_cnt <= 4'd1) begin
          if (w_hold_full) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_state_nxt = ST_GUARD;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // A load overrides whatever the state branch chose.
    w_state_nxt      = w_load ? ST_SHIFT                 : w_state_nxt;
    w_dout_nxt       = w_load ? first_bit(w_hold_data)   : w_dout_nxt;
    w_dout_valid_nxt = w_load ? 1'b1                     : w_dout_valid_nxt;
    w_shreg_nxt      = w_load ? advance(w_hold_data)     : w_shreg_nxt;
    w_cnt_nxt        = w_load ? CNT_ONE                  : w_cnt_nxt;
  end

  // State and datapath registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state      <= ST_IDLE;
      r_shreg      <= '0;
      r_cnt        <= '0;
      r_gap_cnt    <= 4'd0;
      r_dout       <= 1'b0;
      r_dout_valid <= 1'b0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shreg      <= w_shreg_nxt;
      r_cnt        <= w_cnt_nxt;
      r_gap_cnt    <= w_gap_cnt_nxt;
      r_dout       <= w_dout_nxt;
      r_dout_valid <= w_dout_valid_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_busy       <= (w_state_nxt != ST_IDLE);
    end
  end

  assign Dout       = r_dout;
  assign Dout_valid = r_dout_valid;
  assign Frame_done = r_frame_done;
  assign Busy       = r_busy;

endmodule
